load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/riscv_lsu_pkg.sv | 33 +++
 rtl/lsu_byte_lane.sv | 44 ++++
 rtl/load_store_unit.sv | 153 +++++++++++++++
 tb/tb_load_store_unit.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_lsu_pkg.sv
// Shared types for the load/store unit: access-size encodings, FSM states
// and the alignment rule used when misaligned trapping is built in.
package riscv_lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'b00,
    SZ_HALF  = 2'b01,
    SZ_WORD  = 2'b10,
    SZ_WORD2 = 2'b11   // reserved encoding, behaves as a word
  } lsu_size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    RESP  = 2'b11
  } lsu_state_e;

  // Word access for both 10 and 11 encodings.
  function automatic logic is_word(input lsu_size_e size);
    return size[1];
  endfunction

  // Halves must sit on even addresses, words on multiples of four.
  function automatic logic is_misaligned(input lsu_size_e size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return off[0];
      default: return off != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational lane logic: pulls the addressed byte/half out of a memory
// word and extends it for loads, and merges store data into that lane for
// read-modify-write stores. Half lane uses off_i[1] only and word accesses
// ignore the offset, which is how misaligned accesses get forced aligned.
module lsu_byte_lane
  import riscv_lsu_pkg::*;
(
  input  logic [31:0] rword_i,
  input  logic [1:0]  off_i,
  input  lsu_size_e   size_i,
  input  logic        unsigned_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane extract/extend for loads and lane replacement for stores.
  always_comb begin
    byte_sel = rword_i[{off_i, 3'b000} +: 8];
    half_sel = rword_i[{off_i[1], 4'b0000} +: 16];
    load_o   = rword_i;
    merge_o  = wdata_i;
    case (size_i)
      SZ_BYTE: begin
        load_o  = unsigned_i ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
        merge_o = rword_i;
        merge_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
      end
      SZ_HALF: begin
        load_o  = unsigned_i ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
        merge_o = rword_i;
        merge_o[{off_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      end
      default: begin
        load_o  = rword_i;
        merge_o = wdata_i;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between a core request port and a single-ported,
// combinational-read word memory. Sub-word stores are done as a
// read-modify-write. Optional build macro LSU_MISALIGN_TRAP_EN: when defined,
// misaligned half/word accesses complete immediately with rsp_err set and no
// memory access; otherwise they are forced aligned and rsp_err is always 0.
module load_store_unit
  import riscv_lsu_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);

  localparam int AW = $clog2(DEPTH);

  lsu_state_e  state_q;
  logic        we_q;
  lsu_size_e   size_q;
  logic        uns_q;
  logic [1:0]  off_q;
  logic [31:0] wdata_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic        mem_we_q;
  logic [31:0] lane_load;
  logic [31:0] lane_merge;
  lsu_size_e   req_size_e;

  // Address bits above the memory index only wrap, so they are never used.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:AW+2];

  assign req_size_e = lsu_size_e'(req_size);

  lsu_byte_lane u_lane (
    .rword_i    (mem_rdata),
    .off_i      (off_q),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .wdata_i    (wdata_q),
    .load_o     (lane_load),
    .merge_o    (lane_merge)
  );

`ifdef LSU_MISALIGN_TRAP_EN
  logic rsp_err_q;
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;

  // Request FSM with all outputs registered on state entry.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      size_q      <= SZ_BYTE;
      uns_q       <= 1'b0;
      off_q       <= 2'b00;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          rsp_valid_q <= 1'b0;
          mem_we_q    <= 1'b0;
          if (req_valid) begin
            we_q       <= req_we;
            size_q     <= req_size_e;
            uns_q      <= req_unsigned;
            off_q      <= req_addr[1:0];
            wdata_q    <= req_wdata;
            mem_addr_q <= 32'(req_addr[AW+1:2]);
`ifdef LSU_MISALIGN_TRAP_EN
            if (is_misaligned(req_size_e, req_addr[1:0])) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= '0;
              rsp_err_q   <= 1'b1;
            end else
`endif
            if (req_we && is_word(req_size_e)) begin
              state_q     <= WRITE;
              mem_we_q    <= 1'b1;
              mem_wdata_q <= req_wdata;
            end else begin
              state_q <= READ;
            end
          end
        end
        READ: begin
          if (!we_q) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= lane_load;
`ifdef LSU_MISALIGN_TRAP_EN
            rsp_err_q   <= 1'b0;
`endif
          end else begin
            state_q     <= WRITE;
            mem_we_q    <= 1'b1;
            mem_wdata_q <= lane_merge;
          end
        end
        WRITE: begin
          state_q     <= RESP;
          mem_we_q    <= 1'b0;
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
          rsp_err_q   <= 1'b0;
`endif
        end
        default: begin
          state_q     <= IDLE;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural word memory.
module tb_load_store_unit;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  logic [31:0] mem [256];
  logic        pl_en;
  logic [7:0]  pl_idx;
  logic [31:0] pl_data;

  int vectors;
  int miscompares;

  int          t_lat;
  logic        t_we;
  logic [31:0] t_widx;
  logic [31:0] t_wdata;
  logic [31:0] t_rdata;
  logic        t_err;
  logic        t_after;

  load_store_unit #(.DEPTH(256)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign mem_rdata = mem[mem_addr[7:0]];

  always @(posedge clock) begin
    if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
    else if (pl_en) mem[pl_idx] <= pl_data;
  end

  task automatic poke(input logic [7:0] idx, input logic [31:0] data);
    @(negedge clock);
    pl_en = 1'b1; pl_idx = idx; pl_data = data;
    @(posedge clock); #1;
    pl_en = 1'b0;
  endtask

  // One request; records latency, any write seen, and the response.
  task automatic txn(input logic we, input logic [1:0] sz, input logic uns,
                     input logic [31:0] a, input logic [31:0] wd);
    @(negedge clock);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    @(posedge clock); #1;
    req_valid = 1'b0; req_we = 1'b0;
    t_lat = 1; t_we = 1'b0; t_widx = '0; t_wdata = '0;
    while (!rsp_valid && t_lat < 10) begin
      if (mem_we) begin t_we = 1'b1; t_widx = mem_addr; t_wdata = mem_wdata; end
      @(posedge clock); #1;
      t_lat++;
    end
    t_rdata = rsp_rdata;
    t_err   = rsp_err;
    @(posedge clock); #1;
    t_after = rsp_valid;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    #12;
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready got %b want 1", req_ready); end
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rst_rsp_valid got %b want 0", rsp_valid); end
    vectors++; if (rsp_rdata !== 32'h0) begin miscompares++; $display("FAIL rst_rdata got %h want 0", rsp_rdata); end
    vectors++; if (rsp_err !== 1'b0) begin miscompares++; $display("FAIL rst_err got %b want 0", rsp_err); end
    vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL rst_mem_we got %b want 0", mem_we); end
    vectors++; if (mem_addr !== 32'h0) begin miscompares++; $display("FAIL rst_mem_addr got %h want 0", mem_addr); end
    vectors++; if (mem_wdata !== 32'h0) begin miscompares++; $display("FAIL rst_mem_wdata got %h want 0", mem_wdata); end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_word;
    txn(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    vectors++; if (t_lat !== 2) begin miscompares++; $display("FAIL sw_lat got %0d want 2", t_lat); end
    vectors++; if (t_we !== 1'b1 || t_widx !== 32'd4) begin miscompares++; $display("FAIL sw_we got we=%b idx=%h want we=1 idx=4", t_we, t_widx); end
    vectors++; if (t_wdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL sw_wdata got %h want deadbeef", t_wdata); end
    vectors++; if (t_rdata !== 32'h0) begin miscompares++; $display("FAIL sw_rdata got %h want 0", t_rdata); end
    vectors++; if (t_after !== 1'b0) begin miscompares++; $display("FAIL sw_pulse got %b want 0", t_after); end
    txn(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    vectors++; if (t_lat !== 2) begin miscompares++; $display("FAIL lw_lat got %0d want 2", t_lat); end
    vectors++; if (t_rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL lw_rdata got %h want deadbeef", t_rdata); end
    vectors++; if (t_err !== 1'b0) begin miscompares++; $display("FAIL lw_err got %b want 0", t_err); end
    vectors++; if (t_we !== 1'b0) begin miscompares++; $display("FAIL lw_we got %b want 0", t_we); end
    @(posedge clock); #1;
    vectors++; if (rsp_rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL lw_hold got %h want deadbeef", rsp_rdata); end
  endtask

  task automatic test_ignore;
    @(negedge clock);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h0;
    @(posedge clock); #1;
    req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'h12345678;
    vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL ign_busy got %b want 0", req_ready); end
    @(posedge clock); #1;
    vectors++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL ign_rsp got v=%b d=%h want v=1 d=deadbeef", rsp_valid, rsp_rdata); end
    req_valid = 1'b0; req_we = 1'b0;
    @(posedge clock); #1;
    vectors++; if (mem_we !== 1'b0 || req_ready !== 1'b1) begin miscompares++; $display("FAIL ign_idle got we=%b rdy=%b want we=0 rdy=1", mem_we, req_ready); end
  endtask

  task automatic test_byte;
    poke(8'd4, 32'h0);
    txn(1'b1, 2'b00, 1'b0, 32'h11, 32'h0000007F);
    vectors++; if (t_lat !== 3) begin miscompares++; $display("FAIL sb_lat got %0d want 3", t_lat); end
    vectors++; if (mem[4] !== 32'h00007F00) begin miscompares++; $display("FAIL sb_mem got %h want 00007f00", mem[4]); end
    txn(1'b0, 2'b00, 1'b0, 32'h11, 32'h0);
    vectors++; if (t_rdata !== 32'h0000007F) begin miscompares++; $display("FAIL lb11_rdata got %h want 0000007f", t_rdata); end
    txn(1'b1, 2'b00, 1'b0, 32'h13, 32'h123456AB);
    vectors++; if (mem[4] !== 32'hAB007F00) begin miscompares++; $display("FAIL sb13_mem got %h want ab007f00", mem[4]); end
    txn(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
    vectors++; if (t_rdata !== 32'hFFFFFFAB) begin miscompares++; $display("FAIL lb13_rdata got %h want ffffffab", t_rdata); end
  endtask

  task automatic test_half;
    poke(8'd8, 32'h8000FF80);
    txn(1'b0, 2'b01, 1'b0, 32'h22, 32'h0);
    vectors++; if (t_rdata !== 32'hFFFF8000) begin miscompares++; $display("FAIL lh22_rdata got %h want ffff8000", t_rdata); end
    txn(1'b0, 2'b00, 1'b1, 32'h20, 32'h0);
    vectors++; if (t_rdata !== 32'h00000080) begin miscompares++; $display("FAIL lbu20_rdata got %h want 00000080", t_rdata); end
    txn(1'b0, 2'b00, 1'b0, 32'h20, 32'h0);
    vectors++; if (t_rdata !== 32'hFFFFFF80) begin miscompares++; $display("FAIL lb20_rdata got %h want ffffff80", t_rdata); end
    txn(1'b0, 2'b01, 1'b1, 32'h20, 32'h0);
    vectors++; if (t_rdata !== 32'h0000FF80) begin miscompares++; $display("FAIL lhu20_rdata got %h want 0000ff80", t_rdata); end
    txn(1'b1, 2'b01, 1'b0, 32'h22, 32'hAAAA1234);
    vectors++; if (t_lat !== 3 || mem[8] !== 32'h1234FF80) begin miscompares++; $display("FAIL sh22 got lat=%0d mem=%h want lat=3 mem=1234ff80", t_lat, mem[8]); end
  endtask

  task automatic test_wrap;
    txn(1'b1, 2'b10, 1'b0, 32'h400, 32'hCAFEF00D);
    vectors++; if (t_we !== 1'b1 || t_widx !== 32'h0) begin miscompares++; $display("FAIL wrap_idx got we=%b idx=%h want we=1 idx=0", t_we, t_widx); end
    vectors++; if (mem[0] !== 32'hCAFEF00D) begin miscompares++; $display("FAIL wrap_mem got %h want cafef00d", mem[0]); end
  endtask

  task automatic test_misalign;
    txn(1'b0, 2'b11, 1'b0, 32'h20, 32'h0);
    vectors++; if (t_rdata !== 32'h1234FF80 || t_lat !== 2) begin miscompares++; $display("FAIL lsz3 got %h lat=%0d want 1234ff80 lat=2", t_rdata, t_lat); end
`ifdef LSU_MISALIGN_TRAP_EN
    txn(1'b0, 2'b01, 1'b0, 32'h21, 32'h0);
    vectors++; if (t_err !== 1'b1 || t_rdata !== 32'h0) begin miscompares++; $display("FAIL lh21 got err=%b d=%h want err=1 d=0", t_err, t_rdata); end
    vectors++; if (t_we !== 1'b0 || t_lat !== 1) begin miscompares++; $display("FAIL lh21_acc got we=%b lat=%0d want we=0 lat=1", t_we, t_lat); end
    txn(1'b0, 2'b10, 1'b0, 32'h23, 32'h0);
    vectors++; if (t_err !== 1'b1 || t_rdata !== 32'h0) begin miscompares++; $display("FAIL lw23 got err=%b d=%h want err=1 d=0", t_err, t_rdata); end
    txn(1'b1, 2'b01, 1'b0, 32'h21, 32'h0000BEEF);
    vectors++; if (t_we !== 1'b0 || t_err !== 1'b1 || mem[8] !== 32'h1234FF80) begin miscompares++; $display("FAIL sh21 got we=%b err=%b mem=%h want we=0 err=1 mem=1234ff80", t_we, t_err, mem[8]); end
`else
    txn(1'b0, 2'b01, 1'b0, 32'h21, 32'h0);
    vectors++; if (t_err !== 1'b0 || t_rdata !== 32'hFFFFFF80) begin miscompares++; $display("FAIL lh21 got err=%b d=%h want err=0 d=ffffff80", t_err, t_rdata); end
    vectors++; if (t_we !== 1'b0 || t_lat !== 2) begin miscompares++; $display("FAIL lh21_acc got we=%b lat=%0d want we=0 lat=2", t_we, t_lat); end
    txn(1'b0, 2'b10, 1'b0, 32'h23, 32'h0);
    vectors++; if (t_err !== 1'b0 || t_rdata !== 32'h1234FF80) begin miscompares++; $display("FAIL lw23 got err=%b d=%h want err=0 d=1234ff80", t_err, t_rdata); end
    txn(1'b1, 2'b01, 1'b0, 32'h21, 32'h0000BEEF);
    vectors++; if (t_we !== 1'b1 || t_err !== 1'b0 || mem[8] !== 32'h1234BEEF) begin miscompares++; $display("FAIL sh21 got we=%b err=%b mem=%h want we=1 err=0 mem=1234beef", t_we, t_err, mem[8]); end
`endif
  endtask

  task automatic test_reset_mid;
    poke(8'd5, 32'h11111111);
    @(negedge clock);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h14; req_wdata = 32'h55555555;
    @(posedge clock); #1;
    req_valid = 1'b0; req_we = 1'b0;
    vectors++; if (mem_we !== 1'b1) begin miscompares++; $display("FAIL rm_write got %b want 1", mem_we); end
    #1 reset = 1'b1;
    #1;
    vectors++; if (mem_we !== 1'b0 || req_ready !== 1'b1) begin miscompares++; $display("FAIL rm_async got we=%b rdy=%b want we=0 rdy=1", mem_we, req_ready); end
    @(posedge clock); #1;
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    vectors++; if (mem[5] !== 32'h11111111) begin miscompares++; $display("FAIL rm_mem got %h want 11111111", mem[5]); end
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rm_rsp got %b want 0", rsp_valid); end
    txn(1'b0, 2'b10, 1'b0, 32'h14, 32'h0);
    vectors++; if (t_rdata !== 32'h11111111 || t_lat !== 2) begin miscompares++; $display("FAIL rm_recover got %h lat=%0d want 11111111 lat=2", t_rdata, t_lat); end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0;
    pl_en = 1'b0; pl_idx = '0; pl_data = '0;
    test_reset;
    test_word;
    test_ignore;
    test_byte;
    test_half;
    test_wrap;
    test_misalign;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
